// File: rtl/mor1kx_store_buffer_drain_pkg.sv
// Shared definitions for the store buffer drain engine: FSM state encoding
// and byte-select width helpers.
package mor1kx_store_buffer_drain_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_ERROR = 3'd4
  } drain_state_t;

  localparam int BYTE_W = 8;

  // Gap counter width; never zero so the register stays legal when no gap is configured.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 0) ? $clog2(gap + 1) : 1;
  endfunction

endpackage

// File: rtl/mor1kx_store_buffer_drain.sv
// Store buffer drain: pops one buffered store at a time and issues it as a
// single-beat data-bus write, reporting bus errors and drain completion.
module mor1kx_store_buffer_drain
  import mor1kx_store_buffer_drain_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_DRAIN_GAP     = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   sb_empty_i,
  output logic                                   sb_read_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]        sb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]        sb_dat_i,
  input  logic [OPTION_OPERAND_WIDTH/BYTE_W-1:0] sb_bsel_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]        sb_pc_i,
  input  logic                                   bus_grant_i,
  output logic                                   dbus_req_o,
  output logic                                   dbus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]        dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]        dbus_dat_o,
  output logic [OPTION_OPERAND_WIDTH/BYTE_W-1:0] dbus_bsel_o,
  input  logic                                   dbus_ack_i,
  input  logic                                   dbus_err_i,
  output logic                                   store_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]        err_pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]        err_adr_o,
  input  logic                                   err_clear_i,
  output logic                                   drained_o
);

  localparam int W      = OPTION_OPERAND_WIDTH;
  localparam int BSEL_W = W / BYTE_W;
  localparam int CNT_W  = gap_cnt_w(OPTION_DRAIN_GAP);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((OPTION_DRAIN_GAP > 0) ? OPTION_DRAIN_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  drain_state_t     state;
  drain_state_t     state_next;
  logic [W-1:0]     store_pc;
  logic [CNT_W-1:0] gap_cnt;
  logic             can_pop;
  logic             bus_done;
  logic             bus_fail;

  assign can_pop  = !sb_empty_i && bus_grant_i;
  // Error wins over a simultaneous ack.
  assign bus_fail = (state == S_WRITE) && dbus_err_i;
  assign bus_done = (state == S_WRITE) && dbus_ack_i && !dbus_err_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (can_pop) state_next = S_FETCH;
      S_FETCH: state_next = S_WRITE;
      S_WRITE: begin
        if (bus_fail) begin
          state_next = S_ERROR;
        end else if (bus_done) begin
          if (OPTION_DRAIN_GAP > 0) begin
            state_next = S_GAP;
          end else if (can_pop) begin
            state_next = S_FETCH;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_GAP:   if (gap_cnt == GAP_LAST) state_next = S_IDLE;
      S_ERROR: if (err_clear_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Request is a pure decode of state so reset removes it asynchronously.
  always_comb begin
    sb_read_o = 1'b0;
    unique case (state)
      S_IDLE:  sb_read_o = can_pop;
      S_WRITE: sb_read_o = (OPTION_DRAIN_GAP == 0) && bus_done && can_pop;
      default: sb_read_o = 1'b0;
    endcase
    dbus_req_o = (state == S_WRITE);
    dbus_we_o  = (state == S_WRITE);
    drained_o  = (state == S_IDLE) && sb_empty_i && !store_err_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus_adr_o  <= '0;
      dbus_dat_o  <= '0;
      dbus_bsel_o <= {BSEL_W{1'b0}};
      store_pc    <= '0;
      store_err_o <= 1'b0;
      err_pc_o    <= '0;
      err_adr_o   <= '0;
      gap_cnt     <= '0;
    end else begin
      if (state == S_FETCH) begin
        dbus_adr_o  <= sb_adr_i;
        dbus_dat_o  <= sb_dat_i;
        dbus_bsel_o <= sb_bsel_i;
        store_pc    <= sb_pc_i;
      end
      if (bus_fail) begin
        store_err_o <= 1'b1;
        err_pc_o    <= store_pc;
        err_adr_o   <= dbus_adr_o;
      end else if ((state == S_ERROR) && err_clear_i) begin
        store_err_o <= 1'b0;
      end
      if (state != S_GAP) begin
        gap_cnt <= '0;
      end else if (gap_cnt != CNT_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_store_buffer_drain.sv
// Bench for mor1kx_store_buffer_drain: FIFO and bus responder models with an
// in-order expected-write queue, directed scenarios and a randomized drain.
`timescale 1ns/1ps
module tb_mor1kx_store_buffer_drain;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    logic [31:0] pc;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sb_empty = 1'b1;
  logic        sb_read;
  logic [31:0] sb_adr = '0;
  logic [31:0] sb_dat = '0;
  logic [3:0]  sb_bsel = '0;
  logic [31:0] sb_pc = '0;
  logic        grant = 1'b0;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat;
  logic [3:0]  dbus_bsel;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic        store_err;
  logic [31:0] err_pc;
  logic [31:0] err_adr;
  logic        err_clear = 1'b0;
  logic        drained;

  always #5 clk = ~clk;

  mor1kx_store_buffer_drain #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_DRAIN_GAP(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sb_empty_i(sb_empty), .sb_read_o(sb_read),
    .sb_adr_i(sb_adr), .sb_dat_i(sb_dat), .sb_bsel_i(sb_bsel), .sb_pc_i(sb_pc),
    .bus_grant_i(grant),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we),
    .dbus_adr_o(dbus_adr), .dbus_dat_o(dbus_dat), .dbus_bsel_o(dbus_bsel),
    .dbus_ack_i(ack), .dbus_err_i(err),
    .store_err_o(store_err), .err_pc_o(err_pc), .err_adr_o(err_adr),
    .err_clear_i(err_clear), .drained_o(drained)
  );

  st_t fifo[$];
  st_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  n_pops = 0;
  int  n_done = 0;
  int  wait_cnt = 0;
  int  lat = 0;
  int  err_idx = -1;
  bit  err_both = 1'b0;
  int  pop_in_ack = 0;
  int  req_cycles = 0;
  int  last_pop_cyc = -1;
  int  req_rise_cyc = -1;
  logic req_prev = 1'b0;

  task automatic push(input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] bsel, input logic [31:0] pc);
    st_t e;
    e.adr = adr; e.dat = dat; e.bsel = bsel; e.pc = pc;
    fifo.push_back(e);
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs at the falling edge, respond as the bus, advance the FIFO model.
  task automatic step();
    logic pop, done, was_err;
    st_t e, ep;
    sb_empty = (fifo.size() == 0);
    ack = 1'b0;
    err = 1'b0;
    #1;
    if (dbus_req) begin
      if (!req_prev) req_rise_cyc = cyc;
      req_cycles++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_req cyc=%0d got adr=%h, no store outstanding", cyc, dbus_adr);
      end else begin
        e = exp_q[0];
        vectors++;
        if (dbus_adr !== e.adr || dbus_dat !== e.dat || dbus_bsel !== e.bsel || dbus_we !== 1'b1) begin
          miscompares++;
          $display("FAIL write_payload cyc=%0d got %h/%h/%h we=%b want %h/%h/%h we=1",
                   cyc, dbus_adr, dbus_dat, dbus_bsel, dbus_we, e.adr, e.dat, e.bsel);
        end
      end
      if (wait_cnt >= lat) begin
        if (n_done == err_idx) begin
          err = 1'b1;
          ack = err_both;
        end else begin
          ack = 1'b1;
        end
      end
      wait_cnt++;
    end
    req_prev = dbus_req;
    #1;
    vectors++;
    if (sb_read === 1'b1 && sb_empty === 1'b1) begin
      miscompares++;
      $display("FAIL underflow_pop cyc=%0d got sb_read=1 want 0 while empty", cyc);
    end
    pop = sb_read;
    if (pop) last_pop_cyc = cyc;
    if (pop && ack) pop_in_ack++;
    done = dbus_req && (ack || err);
    was_err = err;
    @(posedge clk);
    #1;
    if (pop && fifo.size() > 0) begin
      ep = fifo.pop_front();
      sb_adr = ep.adr; sb_dat = ep.dat; sb_bsel = ep.bsel; sb_pc = ep.pc;
      n_pops++;
    end
    if (done) begin
      wait_cnt = 0;
      n_done++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (was_err) begin
          vectors++;
          if (store_err !== 1'b1 || err_pc !== e.pc || err_adr !== e.adr) begin
            miscompares++;
            $display("FAIL err_latch got err=%b pc=%h adr=%h want err=1 pc=%h adr=%h",
                     store_err, err_pc, err_adr, e.pc, e.adr);
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_empty(input int limit);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < limit) begin
      step();
      g++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d stores left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    grant = 1'b0;
    sb_empty = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sb_read, dbus_req, dbus_we, dbus_adr, dbus_dat, dbus_bsel, store_err, err_pc, err_adr, drained} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got req=%b rd=%b adr=%h err=%b drained=%b want all 0",
               dbus_req, sb_read, dbus_adr, store_err, drained);
    end
    rst_n = 1'b1;
    grant = 1'b1;
    step();
    vectors++;
    if (drained !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_drained got %b want 1", drained);
    end
  endtask

  task automatic test_single_store();
    int p0, rc0;
    lat = 3; grant = 1'b1;
    p0 = n_pops; rc0 = req_cycles;
    push(32'h100, 32'hDEADBEEF, 4'hF, 32'h1000);
    run_until_empty(30);
    vectors++;
    if (n_pops - p0 != 1) begin
      miscompares++;
      $display("FAIL single_pops got %0d want 1", n_pops - p0);
    end
    vectors++;
    if (req_rise_cyc - last_pop_cyc != 2) begin
      miscompares++;
      $display("FAIL pop_to_req got %0d want 2", req_rise_cyc - last_pop_cyc);
    end
    vectors++;
    if (req_cycles - rc0 != 4) begin
      miscompares++;
      $display("FAIL single_req_len got %0d want 4", req_cycles - rc0);
    end
    vectors++;
    if (drained !== 1'b1 || dbus_req !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drained got drained=%b req=%b want 1/0", drained, dbus_req);
    end
  endtask

  task automatic test_back_to_back();
    int p0, c0, a0;
    lat = 0; grant = 1'b1;
    p0 = n_pops; c0 = cyc; a0 = pop_in_ack;
    for (int i = 0; i < 4; i++) push(32'h300 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(i + 1), 32'h1100 + 32'(i * 4));
    run_until_empty(40);
    vectors++;
    if (n_pops - p0 != 4) begin
      miscompares++;
      $display("FAIL b2b_pops got %0d want 4", n_pops - p0);
    end
    vectors++;
    if (pop_in_ack - a0 != 3) begin
      miscompares++;
      $display("FAIL b2b_pop_in_ack got %0d want 3", pop_in_ack - a0);
    end
    vectors++;
    if (cyc - c0 != 9) begin
      miscompares++;
      $display("FAIL b2b_cycles got %0d want 9", cyc - c0);
    end
  endtask

  task automatic test_grant_withheld();
    int p0, rc0;
    lat = 3; grant = 1'b0;
    p0 = n_pops; rc0 = req_cycles;
    push(32'h600, 32'h1234_5678, 4'h3, 32'h1200);
    repeat (5) step();
    vectors++;
    if (n_pops != p0 || req_cycles != rc0) begin
      miscompares++;
      $display("FAIL no_grant got pops=%0d reqs=%0d want 0/0", n_pops - p0, req_cycles - rc0);
    end
    grant = 1'b1;
    step();
    vectors++;
    if (last_pop_cyc != cyc - 1 || n_pops - p0 != 1) begin
      miscompares++;
      $display("FAIL first_grant_pop got pop_cyc=%0d want %0d", last_pop_cyc, cyc - 1);
    end
    step();
    grant = 1'b0;
    run_until_empty(30);
    vectors++;
    if (req_cycles - rc0 != 4) begin
      miscompares++;
      $display("FAIL held_without_grant got %0d req cycles want 4", req_cycles - rc0);
    end
    grant = 1'b1;
  endtask

  task automatic test_bus_error();
    int g, p0, rc0;
    lat = 1; grant = 1'b1;
    err_idx = n_done + 1;
    push(32'h204, 32'h1111_1111, 4'hF, 32'h2000);
    push(32'h208, 32'h2222_2222, 4'hF, 32'h2004);
    push(32'h20C, 32'h3333_3333, 4'hF, 32'h2008);
    g = 0;
    while (store_err !== 1'b1 && g < 40) begin
      step();
      g++;
    end
    vectors++;
    if (store_err !== 1'b1 || err_pc !== 32'h2004 || err_adr !== 32'h208) begin
      miscompares++;
      $display("FAIL bus_error got err=%b pc=%h adr=%h want 1/00002004/00000208", store_err, err_pc, err_adr);
    end
    p0 = n_pops; rc0 = req_cycles;
    repeat (5) step();
    vectors++;
    if (n_pops != p0 || req_cycles != rc0 || store_err !== 1'b1 || drained !== 1'b0) begin
      miscompares++;
      $display("FAIL error_hold got pops=%0d reqs=%0d err=%b drained=%b want 0/0/1/0",
               n_pops - p0, req_cycles - rc0, store_err, drained);
    end
    err_idx = -1;
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    vectors++;
    if (store_err !== 1'b0 || err_pc !== 32'h2004 || err_adr !== 32'h208) begin
      miscompares++;
      $display("FAIL err_clear got err=%b pc=%h adr=%h want 0/00002004/00000208", store_err, err_pc, err_adr);
    end
    run_until_empty(30);
    vectors++;
    if (n_pops - p0 != 1) begin
      miscompares++;
      $display("FAIL resume_after_clear got %0d pops want 1", n_pops - p0);
    end
  endtask

  task automatic test_ack_and_err();
    int g;
    lat = 2; grant = 1'b1;
    err_both = 1'b1;
    err_idx = n_done;
    push(32'h400, 32'h5555_AAAA, 4'h5, 32'h3000);
    g = 0;
    while (store_err !== 1'b1 && g < 30) begin
      step();
      g++;
    end
    vectors++;
    if (store_err !== 1'b1 || err_adr !== 32'h400 || err_pc !== 32'h3000 || dbus_req !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_err_same got err=%b adr=%h pc=%h req=%b want 1/00000400/00003000/0",
               store_err, err_adr, err_pc, dbus_req);
    end
    err_both = 1'b0;
    err_idx = -1;
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int g, p0;
    lat = 20; grant = 1'b1;
    push(32'h500, 32'h0BAD_F00D, 4'hC, 32'h4000);
    push(32'h504, 32'h600D_F00D, 4'h3, 32'h4004);
    g = 0;
    while (dbus_req !== 1'b1 && g < 10) begin
      step();
      g++;
    end
    grant = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dbus_req !== 1'b0 || dbus_we !== 1'b0 || sb_read !== 1'b0 || dbus_adr !== '0) begin
      miscompares++;
      $display("FAIL async_reset_req got req=%b we=%b rd=%b adr=%h want 0/0/0/0", dbus_req, dbus_we, sb_read, dbus_adr);
    end
    void'(exp_q.pop_front());
    wait_cnt = 0;
    req_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({sb_read, dbus_req, dbus_adr, dbus_dat, dbus_bsel, store_err} !== '0) begin
      miscompares++;
      $display("FAIL post_reset_idle got req=%b rd=%b adr=%h err=%b want all 0", dbus_req, sb_read, dbus_adr, store_err);
    end
    @(negedge clk);
    p0 = n_pops;
    grant = 1'b1; lat = 0;
    run_until_empty(30);
    vectors++;
    if (n_pops - p0 != 1) begin
      miscompares++;
      $display("FAIL restart_drain got %0d pops want 1", n_pops - p0);
    end
  endtask

  task automatic test_random();
    int p0, pushed, g;
    p0 = n_pops;
    pushed = 0;
    g = 0;
    err_idx = n_done + 10;
    while ((pushed < 40 || exp_q.size() > 0) && g < 3000) begin
      if (pushed < 40 && ($urandom % 3) == 0) begin
        push($urandom, $urandom, 4'($urandom), $urandom);
        pushed++;
      end
      grant = (($urandom % 4) != 0);
      lat = $urandom % 3;
      err_clear = store_err && (($urandom % 2) == 0);
      step();
      g++;
    end
    err_clear = 1'b0;
    err_idx = -1;
    vectors++;
    if (exp_q.size() != 0 || n_pops - p0 != 40) begin
      miscompares++;
      $display("FAIL random_drain got left=%0d pops=%0d want 0/40", exp_q.size(), n_pops - p0);
    end
    if (store_err === 1'b1) begin
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
    end
    step();
    vectors++;
    if (drained !== 1'b1) begin
      miscompares++;
      $display("FAIL random_final_drained got %b want 1", drained);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_store();
    test_back_to_back();
    test_grant_withheld();
    test_bus_error();
    test_ack_and_err();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
